// File: rtl/fq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fq_pkg
// Purpose  : Shared types and constants for the 2-wide fetch queue.
//            Holds the default PC/instruction widths, the queue entry type
//            and the encoding treated as "no instruction" by the optional
//            zero-word filter (macro FQ_ZERO_FILTER_EN).
// Revision : 1.0 - initial release
// ============================================================================
package fq_pkg;

    localparam int FQ_XLEN          = 64;
    localparam int FQ_ILEN          = 32;
    localparam int FQ_DEFAULT_DEPTH = 8;

    // All-zero word: uninitialised memory / illegal encoding.
    localparam logic [FQ_ILEN-1:0] FQ_ZERO_INSTR = 32'h0000_0000;

    // One queue slot holds a single instruction together with its PC.
    typedef struct packed {
        logic [FQ_XLEN-1:0] pc;
        logic [FQ_ILEN-1:0] instr;
    } fq_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_queue_ram.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue_ram
// Purpose  : DEPTH x fq_entry_t storage for the fetch queue.
//            Two synchronous write ports (tail, tail+1) and two
//            asynchronous read ports (head, head+1). Contents are not reset.
// Ports    : clk                 - rising-edge clock
//            i_we0/i_waddr0/i_wdata0 - write port 0
//            i_we1/i_waddr1/i_wdata1 - write port 1
//            i_raddr0/o_rdata0   - async read port 0
//            i_raddr1/o_rdata1   - async read port 1
// Revision : 1.0 - initial release
// ============================================================================
module fetch_queue_ram
    import fq_pkg::*;
#(
    parameter int DEPTH  = FQ_DEFAULT_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_we0,
    input  logic [ADDR_W-1:0] i_waddr0,
    input  fq_entry_t         i_wdata0,
    input  logic              i_we1,
    input  logic [ADDR_W-1:0] i_waddr1,
    input  fq_entry_t         i_wdata1,
    input  logic [ADDR_W-1:0] i_raddr0,
    output fq_entry_t         o_rdata0,
    input  logic [ADDR_W-1:0] i_raddr1,
    output fq_entry_t         o_rdata1
);

    fq_entry_t r_mem [DEPTH];

    // The two write addresses are always distinct (tail and tail+1), so
    // ordering between the ports does not matter.
    always_ff @(posedge clk) begin
        if (i_we0) begin
            r_mem[i_waddr0] <= i_wdata0;
        end
        if (i_we1) begin
            r_mem[i_waddr1] <= i_wdata1;
        end
    end

    assign o_rdata0 = r_mem[i_raddr0];
    assign o_rdata1 = r_mem[i_raddr1];

endmodule
`default_nettype wire

// File: rtl/fetch_queue_2w.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue_2w
// Purpose  : Decoupling instruction queue between a 2-wide fetch stage and a
//            dual-issue decode stage. Accepts a two-word bundle per cycle,
//            presents the oldest two instructions first-word-fall-through,
//            raises stall when fewer than two slots are free, and empties on
//            flush (taken branch).
// Options  : FQ_ZERO_FILTER_EN - drop incoming all-zero words; surviving
//            words are packed starting at tail.
// Ports    : clk, rst (async, active high), flush
//            in_valid, in_pc, in_instr1, in_instr2  - fetch bundle
//            stall                                  - to fetch
//            deq_cnt                                - decode consume count
//            out_valid1/2, out_pc1/2, out_instr1/2  - head and head+1
// Revision : 1.0 - initial release
// ============================================================================
module fetch_queue_2w
    import fq_pkg::*;
#(
    parameter int DEPTH = FQ_DEFAULT_DEPTH,  // power of two, >= 4
    parameter int XLEN  = FQ_XLEN,           // must equal FQ_XLEN (entry type)
    parameter int ILEN  = FQ_ILEN            // must equal FQ_ILEN (entry type)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    input  logic [XLEN-1:0] in_pc,
    input  logic [ILEN-1:0] in_instr1,
    input  logic [ILEN-1:0] in_instr2,
    output logic            stall,
    input  logic [1:0]      deq_cnt,
    output logic            out_valid1,
    output logic            out_valid2,
    output logic [XLEN-1:0] out_pc1,
    output logic [XLEN-1:0] out_pc2,
    output logic [ILEN-1:0] out_instr1,
    output logic [ILEN-1:0] out_instr2
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_STALL_LIMIT = c_CNT_W'(DEPTH - 2);

    logic [c_PTR_W-1:0] r_head;
    logic [c_PTR_W-1:0] r_tail;
    logic [c_CNT_W-1:0] r_count;

    logic               w_stall;
    logic               w_accept;
    logic [c_CNT_W-1:0] w_deq_req;
    logic [c_CNT_W-1:0] w_deq_eff;
    logic [c_CNT_W-1:0] w_enq_num;
    logic [XLEN-1:0]    w_pc_hi;
    fq_entry_t          w_entry_lo;
    fq_entry_t          w_entry_hi;
    logic               w_we0;
    logic               w_we1;
    fq_entry_t          w_wdata0;
    fq_entry_t          w_wdata1;
    fq_entry_t          w_rdata0;
    fq_entry_t          w_rdata1;

    // Stall looks only at registered occupancy; slots freed by this cycle's
    // dequeue become usable on the next cycle.
    assign w_stall  = (r_count > c_STALL_LIMIT);
    assign w_accept = in_valid && !w_stall && !flush;

    // deq_cnt=3 behaves as 2, and never consume more than is held.
    always_comb begin
        w_deq_req = '0;
        case (deq_cnt)
            2'd0:    w_deq_req = '0;
            2'd1:    w_deq_req = c_CNT_W'(1);
            default: w_deq_req = c_CNT_W'(2);
        endcase
    end
    assign w_deq_eff = (w_deq_req > r_count) ? r_count : w_deq_req;

    assign w_pc_hi    = in_pc + XLEN'(4);
    assign w_entry_lo = {in_pc, in_instr1};
    assign w_entry_hi = {w_pc_hi, in_instr2};

`ifdef FQ_ZERO_FILTER_EN
    logic w_keep_lo;
    logic w_keep_hi;

    assign w_keep_lo = (in_instr1 != FQ_ZERO_INSTR);
    assign w_keep_hi = (in_instr2 != FQ_ZERO_INSTR);

    // Port 0 (tail) takes the first surviving word; port 1 (tail+1) is used
    // only when both words survive.
    assign w_we0     = w_accept && (w_keep_lo || w_keep_hi);
    assign w_wdata0  = w_keep_lo ? w_entry_lo : w_entry_hi;
    assign w_we1     = w_accept && w_keep_lo && w_keep_hi;
    assign w_wdata1  = w_entry_hi;
    assign w_enq_num = w_accept ? (c_CNT_W'(w_keep_lo) + c_CNT_W'(w_keep_hi)) : '0;
`else
    assign w_we0     = w_accept;
    assign w_wdata0  = w_entry_lo;
    assign w_we1     = w_accept;
    assign w_wdata1  = w_entry_hi;
    assign w_enq_num = w_accept ? c_CNT_W'(2) : '0;
`endif

    // Flush discards the whole queue, including this cycle's wrong-path
    // bundle and any dequeue decode asked for.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + c_PTR_W'(w_deq_eff);
            r_tail  <= r_tail + c_PTR_W'(w_enq_num);
            r_count <= r_count + w_enq_num - w_deq_eff;
        end
    end

    fetch_queue_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (c_PTR_W)
    ) u_ram (
        .clk      (clk),
        .i_we0    (w_we0),
        .i_waddr0 (r_tail),
        .i_wdata0 (w_wdata0),
        .i_we1    (w_we1),
        .i_waddr1 (r_tail + c_PTR_W'(1)),
        .i_wdata1 (w_wdata1),
        .i_raddr0 (r_head),
        .o_rdata0 (w_rdata0),
        .i_raddr1 (r_head + c_PTR_W'(1)),
        .o_rdata1 (w_rdata1)
    );

    // Fields are zeroed when invalid so stale RAM contents never leak out.
    assign stall      = w_stall;
    assign out_valid1 = (r_count >= c_CNT_W'(1));
    assign out_valid2 = (r_count >= c_CNT_W'(2));
    assign out_pc1    = out_valid1 ? w_rdata0.pc    : '0;
    assign out_instr1 = out_valid1 ? w_rdata0.instr : '0;
    assign out_pc2    = out_valid2 ? w_rdata1.pc    : '0;
    assign out_instr2 = out_valid2 ? w_rdata1.instr : '0;

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue_2w.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_queue_2w
// Purpose  : Self-checking bench for fetch_queue_2w. A queue-based model of
//            the instruction stream holds expected entries; every cycle the
//            DUT outputs are compared against the model's front entries.
// Options  : FQ_ZERO_FILTER_EN - must match the RTL build.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_queue_2w;

    localparam int DEPTH = 8;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [63:0] in_pc;
    logic [31:0] in_instr1;
    logic [31:0] in_instr2;
    logic        stall;
    logic [1:0]  deq_cnt;
    logic        out_valid1;
    logic        out_valid2;
    logic [63:0] out_pc1;
    logic [63:0] out_pc2;
    logic [31:0] out_instr1;
    logic [31:0] out_instr2;

    exp_t mq[$];
    int   n_total = 0;
    int   n_bad   = 0;

    fetch_queue_2w #(
        .DEPTH (DEPTH),
        .XLEN  (64),
        .ILEN  (32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_pc      (in_pc),
        .in_instr1  (in_instr1),
        .in_instr2  (in_instr2),
        .stall      (stall),
        .deq_cnt    (deq_cnt),
        .out_valid1 (out_valid1),
        .out_valid2 (out_valid2),
        .out_pc1    (out_pc1),
        .out_pc2    (out_pc2),
        .out_instr1 (out_instr1),
        .out_instr2 (out_instr2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] wd(input logic [63:0] pc);
        return 32'h0A00_0000 | pc[31:0];
    endfunction

    task automatic check_all();
        int n;
        n = mq.size();
        chk("stall",  64'(stall),      64'(n > DEPTH - 2));
        chk("valid1", 64'(out_valid1), 64'(n >= 1));
        chk("valid2", 64'(out_valid2), 64'(n >= 2));
        chk("pc1",    out_pc1,         (n >= 1) ? mq[0].pc : 64'h0);
        chk("instr1", 64'(out_instr1), (n >= 1) ? 64'(mq[0].instr) : 64'h0);
        chk("pc2",    out_pc2,         (n >= 2) ? mq[1].pc : 64'h0);
        chk("instr2", 64'(out_instr2), (n >= 2) ? 64'(mq[1].instr) : 64'h0);
    endtask

    // Drive one cycle of stimulus, advance the model at the edge, then
    // compare 1 ns after the edge.
    task automatic drive(input logic v, input logic [63:0] pc, input logic [31:0] w1,
                         input logic [31:0] w2, input logic [1:0] dq, input logic fl);
        logic acc;
        int   deq;
        exp_t e;
        in_valid  = v;
        in_pc     = pc;
        in_instr1 = w1;
        in_instr2 = w2;
        deq_cnt   = dq;
        flush     = fl;
        acc = v && !fl && (mq.size() <= DEPTH - 2);
        @(posedge clk);
        if (fl) begin
            mq.delete();
        end else begin
            deq = (dq == 2'd3) ? 2 : int'(dq);
            if (deq > mq.size()) deq = mq.size();
            for (int k = 0; k < deq; k++) void'(mq.pop_front());
            if (acc) begin
`ifdef FQ_ZERO_FILTER_EN
                if (w1 != 32'h0) begin e.pc = pc;      e.instr = w1; mq.push_back(e); end
                if (w2 != 32'h0) begin e.pc = pc + 4;  e.instr = w2; mq.push_back(e); end
`else
                e.pc = pc;     e.instr = w1; mq.push_back(e);
                e.pc = pc + 4; e.instr = w2; mq.push_back(e);
`endif
            end
        end
        #1;
        check_all();
    endtask

    task automatic bundle(input logic [63:0] pc, input logic [1:0] dq);
        drive(1'b1, pc, wd(pc), wd(pc + 4), dq, 1'b0);
    endtask

    task automatic idle(input logic [1:0] dq);
        drive(1'b0, 64'h0, 32'h0, 32'h0, dq, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] pc;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_pc = '0;
        in_instr1 = '0; in_instr2 = '0; deq_cnt = '0;

        // Reset state, then idle after release
        #1;
        chk("rst_stall",  64'(stall),      64'h0);
        chk("rst_valid1", 64'(out_valid1), 64'h0);
        chk("rst_pc1",    out_pc1,         64'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        idle(2'd0);
        idle(2'd2);

        // Basic flow
        drive(1'b1, 64'h0, 32'h0000_0013, 32'h0014_8493, 2'd0, 1'b0);
        chk("basic_pc1",    out_pc1,         64'h0);
        chk("basic_pc2",    out_pc2,         64'h4);
        chk("basic_instr2", 64'(out_instr2), 64'h0014_8493);
        idle(2'd1);
        chk("basic_deq_pc1",  out_pc1,         64'h4);
        chk("basic_deq_val2", 64'(out_valid2), 64'h0);
        idle(2'd1);
        idle(2'd2);   // dequeue request on empty queue

        // Fill to full
        bundle(64'h0,  2'd0);
        bundle(64'h8,  2'd0);
        bundle(64'h10, 2'd0);
        chk("fill6_stall", 64'(stall), 64'h0);
        bundle(64'h18, 2'd0);
        chk("fill8_stall", 64'(stall), 64'h1);
        bundle(64'h20, 2'd0);            // rejected while stalled
        chk("full_pc1", out_pc1, 64'h0);
        idle(2'd2);
        chk("unfull_stall", 64'(stall), 64'h0);
        idle(2'd3);                      // 3 behaves as 2
        chk("deq3_pc1", out_pc1, 64'h10);
        idle(2'd2);
        idle(2'd2);
        idle(2'd1);

        // Wrap-around with continuous flow
        pc = 64'h1000;
        for (int i = 0; i < 20; i++) begin
            bundle(pc, 2'd2);
            chk("wrap_stall", 64'(stall), 64'h0);
            pc += 8;
        end
        idle(2'd2);
        idle(2'd2);

        // Flush with count=5, together with a bundle and a dequeue
        bundle(64'h40, 2'd0);
        bundle(64'h48, 2'd0);
        bundle(64'h50, 2'd0);
        idle(2'd1);
        drive(1'b1, 64'h200, wd(64'h200), wd(64'h204), 2'd2, 1'b1);
        chk("flush_valid1", 64'(out_valid1), 64'h0);
        bundle(64'h100, 2'd0);
        chk("post_flush_pc1", out_pc1, 64'h100);

        // Flush while full and while empty
        bundle(64'h108, 2'd0);
        bundle(64'h110, 2'd0);
        bundle(64'h118, 2'd0);
        drive(1'b0, 64'h0, 32'h0, 32'h0, 2'd0, 1'b1);
        chk("flush_full_stall", 64'(stall), 64'h0);
        drive(1'b0, 64'h0, 32'h0, 32'h0, 2'd2, 1'b1);

`ifdef FQ_ZERO_FILTER_EN
        drive(1'b1, 64'h20, 32'h0, 32'h0014_8593, 2'd0, 1'b0);
        chk("zf_pc1",    out_pc1,         64'h24);
        chk("zf_valid2", 64'(out_valid2), 64'h0);
        drive(1'b1, 64'h28, 32'h0, 32'h0, 2'd0, 1'b0);
        chk("zf_both_valid2", 64'(out_valid2), 64'h0);
        chk("zf_both_pc1",    out_pc1,         64'h24);
`else
        drive(1'b1, 64'h20, 32'h0, 32'h0014_8593, 2'd0, 1'b0);
        chk("nz_pc1",    out_pc1,         64'h20);
        chk("nz_instr1", 64'(out_instr1), 64'h0);
        chk("nz_valid2", 64'(out_valid2), 64'h1);
`endif
        idle(2'd2);
        idle(2'd2);

        // Random traffic
        pc = 64'h4000;
        for (int i = 0; i < 80; i++) begin
            drive(1'($urandom_range(0, 3) != 0), pc, $urandom | 32'h1, $urandom | 32'h1,
                  2'($urandom_range(0, 3)), 1'($urandom_range(0, 11) == 0));
            pc += 8;
        end

        // Reset asserted mid-operation
        bundle(64'h300, 2'd0);
        bundle(64'h308, 2'd0);
        #3 rst = 1'b1;
        #1;
        chk("midrst_stall",  64'(stall),      64'h0);
        chk("midrst_valid1", 64'(out_valid1), 64'h0);
        chk("midrst_pc1",    out_pc1,         64'h0);
        mq.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        idle(2'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_queue_2w.md
Name: fetch_queue_2w

Overview:
- Decoupling instruction queue between the 2-wide fetch stage (PC advancing by 8, two 32-bit words per cycle) and the dual-issue decode stage.
- Enqueues a two-instruction bundle tagged with PCs and presents the oldest two instructions to decode in first-word-fall-through form.
- Drives the fetch stall, which makes fetch hold its PC.
- Flushed on a taken branch.

Parameters:
- DEPTH, 8, queue entries (one instruction per entry); power of two, >= 4.
- XLEN, 64, PC width.
- ILEN, 32, instruction width.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- flush  in  1  taken branch (same signal as fetch branch_en); discards all contents
- in_valid  in  1  fetch bundle valid
- in_pc  in  XLEN  PC of in_instr1; in_instr2 is at in_pc+4
- in_instr1  in  ILEN  word at in_pc
- in_instr2  in  ILEN  word at in_pc+4
- stall  out  1  to fetch: bundle cannot be accepted this cycle
- deq_cnt  in  2  instructions decode consumes this cycle (0..2)
- out_valid1  out  1  head entry valid
- out_valid2  out  1  head+1 entry valid
- out_pc1, out_pc2  out  XLEN  PCs of head and head+1
- out_instr1, out_instr2  out  ILEN  instructions at head and head+1

Behaviour:
- State: storage array[DEPTH] of {pc, instr}; head and tail pointers of log2(DEPTH) bits, wrapping modulo DEPTH; count of log2(DEPTH)+1 bits.
- Reset (async, immediate): head=tail=count=0. Outputs: stall=0, out_valid1/2=0, out_pc*/out_instr*=0. Array contents don't care.
- stall = (count > DEPTH-2), combinational from registered count only. Space freed by a same-cycle dequeue is not visible until the next cycle.
- Enqueue: when in_valid && !stall && !flush, write {in_pc, in_instr1} at tail and {in_pc+4, in_instr2} at tail+1; tail += 2. PC add is XLEN-bit, wrapping.
- Outputs are first-word-fall-through, purely combinational from registered state:
  - out_valid1 = (count >= 1); out_valid2 = (count >= 2).
  - out_pc/out_instr come from head and head+1.
  - A field is forced to 0 when its valid is low.
- Dequeue: effective amount deq_eff = min(deq_cnt, count). deq_cnt=3 is treated as 2. head += deq_eff.
- Simultaneous enqueue and dequeue: count_next = count + enq_num - deq_eff. No conflict, because stall guarantees 2 free slots.
- Latency: an accepted bundle is visible on the outputs one cycle after the accepting edge. No same-cycle bypass.
- Flush: at the next edge head=tail=count=0. The enqueue and dequeue of that cycle are ignored, because the bundle presented during flush is wrong-path.
- Flush while empty or full: same result, all zero.
- Reset asserted mid-operation discards all contents immediately.
- Full boundary, DEPTH=8: count 6 -> stall=0; count 7 or 8 -> stall=1. count never exceeds DEPTH.
- Empty: no dequeue occurs, whatever deq_cnt is.

Optional Feature:
- Macro FQ_ZERO_FILTER_EN.
- When defined, an incoming word equal to 32'h00000000 (uninitialised memory, illegal encoding) is not enqueued:
  - Surviving words are packed in order starting at tail.
  - enq_num ranges 0..2; tail and count advance by enq_num.
  - stall is unchanged (still requires 2 free slots).
- When undefined, both words are always enqueued, zero or not.

Decomposition:
- Package fq_pkg holds:
  - XLEN/ILEN defaults.
  - typedef fq_entry_t {pc, instr}.
  - Constant FQ_ZERO_INSTR = 32'h0.
  - Constant FQ_DEFAULT_DEPTH = 8.
- One sub-module, fetch_queue_ram: DEPTH x fq_entry_t storage with 2 write ports (tail, tail+1) and 2 async read ports (head, head+1).
- Pointer, count and stall logic stays in fetch_queue_2w.

Test Plan:
- Reset then idle:
  - Assert rst mid-cycle -> stall=0, out_valid1/2=0, out_pc1=0 immediately.
  - No change after rst releases with in_valid=0.
- Basic flow:
  - Enqueue in_pc=0x0, words 0x00000013/0x00148493, deq_cnt=0 -> next cycle out_valid1/2=1, out_pc1=0x0, out_pc2=0x4, out_instr2=0x00148493.
  - Then deq_cnt=1 -> out_pc1=0x4, out_valid2=0.
- Fill to full:
  - Bundles at PC 0x0, 0x8, 0x10 with deq_cnt=0 -> count=6, stall=0.
  - Fourth bundle (0x18) accepted -> count=8, stall=1.
  - Bundle at 0x20 not written while stall=1.
  - deq_cnt=2 -> stall deasserts the cycle after.
- Wrap-around: 20 cycles of continuous enqueue with deq_cnt=2 -> output PCs strictly increase by 4 across pointer wrap; stall never asserts; no entry lost or duplicated.
- Flush:
  - With count=5, assert flush together with in_valid and deq_cnt=2 -> next cycle count=0, out_valid1=0.
  - The flush-cycle bundle is absent.
  - A following bundle at 0x100 appears with out_pc1=0x100.
- FQ_ZERO_FILTER_EN defined:
  - Bundle {0x00000000, 0x00148593} at 0x20 -> only one entry, out_pc1=0x24, out_valid2=0.
  - {0,0} -> count unchanged.
